// File: rtl/flt_stim_pkg.sv
// Shared types and constants for the floating-point stimulus sequencer.
// Holds the FSM state enum, the built-in ROM table and width helpers.
package flt_stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  localparam int DEF_N = 10;

  localparam logic [7:0] DEF_ROM [DEF_N] = '{
    8'h48, 8'h65, 8'ha3, 8'h5c, 8'hf2,
    8'hdd, 8'h9b, 8'h62, 8'hd5, 8'h0f
  };

  // Index width, never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must also hold n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/floating_point_stim_rom.sv
// Byte ROM with a one-cycle registered read; out-of-range reads give 0.
// Ports: clk, addr in; data out (registered).
module floating_point_stim_rom
  import flt_stim_pkg::*;
#(
  parameter int    BYTE_W    = 8,
  parameter int    DEPTH     = 10,
  parameter string INIT_FILE = "",
  localparam int   ADDR_W    = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [BYTE_W-1:0] data
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] data_d;
  logic [BYTE_W-1:0] data_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    if (i < DEF_N) begin : g_v
      assign mem[i] = BYTE_W'(DEF_ROM[i]);
    end else begin : g_z
      assign mem[i] = '0;
    end
  end

  always_comb begin
    data_d = '0;
    if ({1'b0, addr} < (ADDR_W + 1)'(DEPTH)) begin
      data_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/floating_point_stim_sequencer.sv
// Streams ROM bytes, packed MSB-first into words, over valid/ready.
// Ports: clk, rst, start, loop_mode, abort, m_ready in; m_* stream, word_idx, busy, done out.
module floating_point_stim_sequencer
  import flt_stim_pkg::*;
#(
  parameter int    BYTE_W     = 8,
  parameter int    DEPTH      = 10,
  parameter int    WORD_BYTES = 2,
  parameter string INIT_FILE  = "",
  localparam int   NUM_WORDS  = DEPTH / WORD_BYTES,
  localparam int   CNT_W      = cnt_width(NUM_WORDS),
  localparam int   DATA_W     = BYTE_W * WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              abort,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  word_idx,
  output logic              busy,
  output logic              done
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam int BC_W   = addr_width(WORD_BYTES + 1);

  if (DEPTH % WORD_BYTES != 0) begin : g_bad_depth
    $error("DEPTH must be a multiple of WORD_BYTES");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [BC_W-1:0]   iss_q, iss_d;
  logic [BC_W-1:0]   cap_q, cap_d;
  logic              req_q, req_d;
  logic              rvld_q, rvld_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] rom_data;
  logic              is_last;

  floating_point_stim_rom #(
    .BYTE_W   (BYTE_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_rom (
    .clk (clk),
    .addr(rd_addr_q),
    .data(rom_data)
  );

  assign is_last = (idx_q == CNT_W'(NUM_WORDS - 1));

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    req_d     = req_q;
    rvld_d    = rvld_q;
    asm_d     = asm_q;
    idx_d     = idx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          rd_addr_d = '0;
          iss_d     = BC_W'(1);
          req_d     = 1'b1;
          cap_d     = '0;
          rvld_d    = 1'b0;
          idx_d     = '0;
        end
      end
      FETCH: begin
        // req marks a live address; rvld marks the ROM byte a cycle later.
        rvld_d = req_q;
        if (iss_q < BC_W'(WORD_BYTES)) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          iss_d     = iss_q + BC_W'(1);
          req_d     = 1'b1;
        end else begin
          req_d = 1'b0;
        end
        if (rvld_q) begin
          asm_d = (asm_q << BYTE_W) | DATA_W'(rom_data);
          cap_d = cap_q + BC_W'(1);
        end
        if (cap_q == BC_W'(WORD_BYTES)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          if (is_last && !loop_mode) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            state_d = FETCH;
            iss_d   = BC_W'(1);
            req_d   = 1'b1;
            cap_d   = '0;
            rvld_d  = 1'b0;
            if (is_last) begin
              idx_d     = '0;
              rd_addr_d = '0;
            end else begin
              // rd_addr still holds the last byte of this word.
              idx_d     = idx_q + CNT_W'(1);
              rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      req_d   = 1'b0;
      rvld_d  = 1'b0;
      iss_d   = '0;
      cap_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      iss_q     <= '0;
      cap_q     <= '0;
      req_q     <= 1'b0;
      rvld_q    <= 1'b0;
      asm_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      iss_q     <= iss_d;
      cap_q     <= cap_d;
      req_q     <= req_d;
      rvld_q    <= rvld_d;
      asm_q     <= asm_d;
      idx_q     <= idx_d;
    end
  end

  assign m_valid  = (state_q == HOLD);
  assign m_last   = (state_q == HOLD) && is_last;
  assign m_data   = asm_q;
  assign word_idx = idx_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_floating_point_stim_sequencer.sv
// Self-checking bench: scoreboard model of the word stream plus directed checks.
// Second instance covers the five-byte word configuration.
module tb_floating_point_stim_sequencer;

  logic        clk = 0;
  logic        rst, start, loop_mode, abort, m_ready;
  logic        m_valid, m_last, busy, done;
  logic [15:0] m_data;
  logic [3:0]  word_idx;

  logic        start1, m_ready1;
  logic        m_valid1, m_last1, busy1, done1;
  logic [39:0] m_data1;
  logic [1:0]  word_idx1;

  int checks = 0;
  int failures = 0;
  int exp_idx = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  bit pend_done = 0;
  bit stall_prev = 0;
  logic [15:0] stall_data;

  logic [7:0] bytes [10] = '{8'h48, 8'h65, 8'ha3, 8'h5c, 8'hf2,
                             8'hdd, 8'h9b, 8'h62, 8'hd5, 8'h0f};

  always #5 clk = ~clk;

  floating_point_stim_sequencer u0 (
    .clk(clk), .rst(rst), .start(start), .loop_mode(loop_mode),
    .abort(abort), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .word_idx(word_idx),
    .busy(busy), .done(done)
  );

  floating_point_stim_sequencer #(.WORD_BYTES(5)) u1 (
    .clk(clk), .rst(rst), .start(start1), .loop_mode(1'b0),
    .abort(1'b0), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_last(m_last1), .word_idx(word_idx1),
    .busy(busy1), .done(done1)
  );

  function automatic logic [15:0] word_of(input int i);
    return {bytes[2*i], bytes[2*i+1]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst || abort) begin
        exp_idx = 0;
        pend_done = 0;
        stall_prev = 0;
      end else begin
        if (done) done_cnt++;
        if (done || pend_done) chk("done_pulse", done, pend_done);
        pend_done = 0;
        if (stall_prev) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, stall_data);
        end
        stall_prev = 0;
        if (m_valid) begin
          chk("m_data", m_data, word_of(exp_idx));
          chk("m_last", m_last, exp_idx == 4);
          chk("word_idx", word_idx, exp_idx);
          if (m_ready) begin
            hs_cnt++;
            if (exp_idx == 4) begin
              exp_idx = 0;
              pend_done = !loop_mode;
            end else begin
              exp_idx++;
            end
          end else begin
            stall_prev = 1;
            stall_data = m_data;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // Counts edges from the start-sampling edge until m_valid rises.
  task automatic latency(input string name);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      n++;
      if (m_valid) seen = 1;
    end
    chk(name, seen ? n : -1, 4);
  endtask

  task automatic wait_done(input int base);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (done_cnt > base) ok = 1;
    end
    chk("pass_done", ok, 1);
  endtask

  task automatic wait_valid1(input logic [39:0] exp, input bit last);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (m_valid1) ok = 1;
    end
    chk("wb5_valid", ok, 1);
    chk("wb5_data", m_data1, exp);
    chk("wb5_last", m_last1, last);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hb, db, st;
    bit hit;
    rst = 1; start = 0; loop_mode = 0; abort = 0; m_ready = 0;
    start1 = 0; m_ready1 = 0;
    fork
      monitor();
    join_none
    tick();
    tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_busy", {busy, done, m_last}, 0);
    rst = 0;
    tick();

    // 1: single pass, always ready
    m_ready = 1;
    hb = hs_cnt; db = done_cnt;
    pulse_start();
    latency("lat_first");
    chk("first_word", m_data, 16'h4865);
    wait_done(db);
    tick();
    chk("t1_words", hs_cnt - hb, 5);
    chk("t1_done_cnt", done_cnt - db, 1);
    chk("t1_busy", busy, 0);

    // 2: stall five cycles on word 2
    m_ready = 0;
    hb = hs_cnt; db = done_cnt; st = 0;
    pulse_start();
    for (int i = 0; i < 300 && done_cnt == db; i++) begin
      if (m_valid && word_idx == 2 && st < 5) begin
        m_ready = 0;
        st++;
      end else begin
        m_ready = 1;
      end
      tick();
    end
    chk("t2_stalls", st, 5);
    chk("t2_words", hs_cnt - hb, 5);
    chk("t2_done_cnt", done_cnt - db, 1);

    // 3: looping, 12 accepts, no done
    loop_mode = 1;
    m_ready = 1;
    hb = hs_cnt; db = done_cnt;
    pulse_start();
    for (int i = 0; i < 400 && hs_cnt - hb < 12; i++) tick();
    m_ready = 0;
    chk("t3_accepts", hs_cnt - hb, 12);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (m_valid) hit = 1;
    end
    chk("t3_next_idx", word_idx, 2);
    chk("t3_next_data", m_data, 16'hf2dd);
    chk("t3_no_done", done_cnt - db, 0);
    abort = 1;
    tick();
    abort = 0;
    loop_mode = 0;
    chk("t3_abort_idle", busy, 0);

    // 4: abort while word 1 is offered with ready high
    m_ready = 1;
    hb = hs_cnt;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_valid && word_idx == 1) hit = 1;
      else tick();
    end
    chk("t4_reach_w1", hit, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("t4_valid", m_valid, 0);
    chk("t4_idx", word_idx, 0);
    chk("t4_busy", {busy, done, m_last}, 0);
    chk("t4_hs", hs_cnt - hb, 1);
    db = done_cnt;
    pulse_start();
    latency("t4_lat");
    chk("t4_restart", m_data, 16'h4865);
    wait_done(db);

    // 5: reset during fetch of word 3, start held during reset
    m_ready = 1;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      if (busy && !m_valid && word_idx == 3) hit = 1;
    end
    chk("t5_reach_w3", hit, 1);
    rst = 1;
    start = 1;
    tick();
    chk("t5_valid", m_valid, 0);
    chk("t5_data", m_data, 0);
    chk("t5_idx", word_idx, 0);
    chk("t5_flags", {busy, done, m_last}, 0);
    tick();
    rst = 0;
    start = 0;
    tick();
    chk("t5_idle", busy, 0);
    db = done_cnt;
    pulse_start();
    latency("t5_lat");
    chk("t5_restart", m_data, 16'h4865);
    wait_done(db);

    // 6: five-byte words
    m_ready1 = 1;
    start1 = 1;
    tick();
    start1 = 0;
    wait_valid1(40'h4865a35cf2, 0);
    wait_valid1(40'hdd9b62d50f, 1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
